// File: rtl/mac_lane_array.sv
// Multi-lane signed MAC engine: shared activation times per-lane weights,
// saturating accumulate, then round/shift, optional ReLU and clamp per lane.
module mac_lane_array #(
  parameter int LANES = 8,
  parameter int DW    = 8,
  parameter int ACCW  = 28,
  parameter int SHW   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic [DW-1:0]         a,
  input  logic [LANES*DW-1:0]   b,
  input  logic [SHW-1:0]        shift,
  input  logic                  relu_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*DW-1:0]   y,
  output logic [LANES-1:0]      overflow,
  input  logic                  ovf_clr
);

  localparam int PW   = 2 * DW;
  localparam int SMAX = ACCW - 1;
  localparam logic signed [ACCW-1:0] L_AMAX = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] L_AMIN = {1'b1, {(ACCW-1){1'b0}}};
  localparam logic signed [ACCW-1:0] L_YMAX = ACCW'(2**(DW-1) - 1);
  localparam logic signed [ACCW-1:0] L_YMIN = ~L_YMAX;

  logic                   r_busy;
  logic                   r_i_vld, r_i_first, r_i_last, r_i_relu;
  logic [SHW-1:0]         r_i_shift;
  logic [DW-1:0]          r_i_a;
  logic [LANES*DW-1:0]    r_i_b;
  logic                   r_p_vld, r_p_first, r_p_last, r_p_relu;
  logic [SHW-1:0]         r_p_shift;
  logic signed [PW-1:0]   r_p_prod [LANES];
  logic                   r_a_done, r_a_relu;
  logic [SHW-1:0]         r_a_shift;
  logic signed [ACCW-1:0] r_acc [LANES];
  logic                   r_out_valid;
  logic [LANES*DW-1:0]    r_y;
  logic [LANES-1:0]       r_ovf;

  logic                   w_accept, w_hs;
  logic signed [ACCW-1:0] w_acc_nx [LANES];
  logic [LANES-1:0]       w_sat;
  logic [LANES*DW-1:0]    w_y;

  assign in_ready  = !r_busy && !rst;
  assign w_accept  = in_valid && in_ready;
  assign w_hs      = r_out_valid && out_ready;
  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign overflow  = r_ovf;

  always_comb begin
    logic signed [ACCW:0]   w_pext, w_sum, w_rnd;
    logic [ACCW:0]          w_half;
    logic signed [ACCW-1:0] w_r, w_t;
    int                     w_s;
    w_sat = '0;
    w_y   = '0;
    w_s   = (int'(r_a_shift) > SMAX) ? SMAX : int'(r_a_shift);
    w_half = '0;
    if (w_s > 0) w_half[w_s-1] = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      w_pext = {{(ACCW+1-PW){r_p_prod[i][PW-1]}}, r_p_prod[i]};
      w_sum  = r_p_first ? w_pext : {r_acc[i][ACCW-1], r_acc[i]} + w_pext;
      if (w_sum[ACCW] != w_sum[ACCW-1]) begin
        w_acc_nx[i] = w_sum[ACCW] ? L_AMIN : L_AMAX;
        w_sat[i]    = r_p_vld;
      end else begin
        w_acc_nx[i] = w_sum[ACCW-1:0];
      end
      // Half-up rounding bias; only a positive overflow is possible here
      w_rnd = {r_acc[i][ACCW-1], r_acc[i]} + $signed(w_half);
      w_r   = (w_rnd[ACCW] != w_rnd[ACCW-1]) ? L_AMAX : w_rnd[ACCW-1:0];
      w_t   = w_r >>> w_s;
      if (r_a_relu && w_t[ACCW-1]) w_t = '0;
      if (w_t > L_YMAX)      w_y[i*DW +: DW] = L_YMAX[DW-1:0];
      else if (w_t < L_YMIN) w_y[i*DW +: DW] = L_YMIN[DW-1:0];
      else                   w_y[i*DW +: DW] = w_t[DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy      <= 1'b0;
      r_i_vld     <= 1'b0;
      r_i_first   <= 1'b0;
      r_i_last    <= 1'b0;
      r_i_relu    <= 1'b0;
      r_i_shift   <= '0;
      r_i_a       <= '0;
      r_i_b       <= '0;
      r_p_vld     <= 1'b0;
      r_p_first   <= 1'b0;
      r_p_last    <= 1'b0;
      r_p_relu    <= 1'b0;
      r_p_shift   <= '0;
      r_a_done    <= 1'b0;
      r_a_relu    <= 1'b0;
      r_a_shift   <= '0;
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_ovf       <= '0;
      for (int i = 0; i < LANES; i++) begin
        r_p_prod[i] <= '0;
        r_acc[i]    <= '0;
      end
    end else begin
      r_i_vld <= w_accept;
      if (w_accept) begin
        r_i_a     <= a;
        r_i_b     <= b;
        r_i_first <= in_first;
        r_i_last  <= in_last;
        r_i_shift <= shift;
        r_i_relu  <= relu_en;
      end
      r_p_vld <= r_i_vld;
      if (r_i_vld) begin
        r_p_first <= r_i_first;
        r_p_last  <= r_i_last;
        r_p_shift <= r_i_shift;
        r_p_relu  <= r_i_relu;
        for (int i = 0; i < LANES; i++)
          r_p_prod[i] <= $signed({{DW{r_i_a[DW-1]}}, r_i_a}) *
                         $signed({{DW{r_i_b[i*DW+DW-1]}}, r_i_b[i*DW +: DW]});
      end
      r_a_done <= r_p_vld && r_p_last;
      if (r_p_vld) begin
        for (int i = 0; i < LANES; i++) r_acc[i] <= w_acc_nx[i];
        if (r_p_last) begin
          r_a_shift <= r_p_shift;
          r_a_relu  <= r_p_relu;
        end
      end
      r_ovf <= (r_ovf & ~{LANES{ovf_clr}}) | w_sat;
      if (r_a_done) begin
        r_out_valid <= 1'b1;
        r_y         <= w_y;
      end else if (w_hs) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept && in_last) r_busy <= 1'b1;
      else if (w_hs)           r_busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_lane_array.sv
// Bench for mac_lane_array: vector table, corner sequences and random
// dot products against a plain-arithmetic reference model.
module tb_mac_lane_array;

  localparam int LANES = 4;
  localparam int DW    = 8;
  localparam int ACCW  = 18;
  localparam int SHW   = 5;
  localparam longint AMAX = (longint'(1) << (ACCW-1)) - 1;
  localparam longint AMIN = -(longint'(1) << (ACCW-1));
  localparam longint YMAX = (longint'(1) << (DW-1)) - 1;
  localparam longint YMIN = -(longint'(1) << (DW-1));

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_first, in_last, relu_en;
  logic out_valid, out_ready, ovf_clr;
  logic [DW-1:0]       a;
  logic [LANES*DW-1:0] b, y;
  logic [SHW-1:0]      shift;
  logic [LANES-1:0]    overflow;

  mac_lane_array #(.LANES(LANES), .DW(DW), .ACCW(ACCW), .SHW(SHW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last), .a(a), .b(b), .shift(shift),
    .relu_en(relu_en), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int ta [40];
  int tw [40][LANES];
  int nb;
  int exp_y [LANES];
  logic [LANES-1:0] exp_ovf, any_sat, fin_sat;

  typedef struct {
    int a;
    int b [LANES];
    int sh;
    bit relu;
    int y [LANES];
  } vec_t;
  vec_t vt [8];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ylane(input int l);
    logic [DW-1:0] v;
    v = y[l*DW +: DW];
    return int'($signed(v));
  endfunction

  // Reference: exact dot product with clamped partial sums, then
  // floor((acc + half) / 2^s), ReLU, clamp to DW.
  function automatic void model(input int sh, input bit relu);
    longint acc, p, s, r, t;
    int se;
    bit sat;
    for (int l = 0; l < LANES; l++) begin
      acc = 0;
      any_sat[l] = 1'b0;
      fin_sat[l] = 1'b0;
      for (int k = 0; k < nb; k++) begin
        p = longint'(ta[k]) * longint'(tw[k][l]);
        s = (k == 0) ? p : acc + p;
        sat = (s > AMAX) || (s < AMIN);
        acc = (s > AMAX) ? AMAX : (s < AMIN) ? AMIN : s;
        if (sat) any_sat[l] = 1'b1;
        if (k == nb - 1) fin_sat[l] = sat;
      end
      se = (sh > ACCW - 1) ? ACCW - 1 : sh;
      r = acc + ((se > 0) ? (longint'(1) << (se - 1)) : 0);
      if (r > AMAX) r = AMAX;
      t = r >>> se;
      if (relu && t < 0) t = 0;
      if (t > YMAX) t = YMAX;
      if (t < YMIN) t = YMIN;
      exp_y[l] = int'(t);
    end
  endfunction

  task automatic drive_beat(input int k, input bit first, input bit last,
                            input int sh, input bit relu);
    in_valid = 1'b1;
    in_first = first;
    in_last  = last;
    a = ta[k][DW-1:0];
    for (int l = 0; l < LANES; l++) b[l*DW +: DW] = tw[k][l][DW-1:0];
    shift   = last ? sh[SHW-1:0] : SHW'($urandom);
    relu_en = last ? relu : 1'($urandom);
  endtask

  task automatic wait_ready(output bit ok);
    int w;
    w = 0;
    in_valid = 1'b0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    ok = in_ready;
    if (!ok) check("in_ready_timeout", 0, 1);
  endtask

  // Beats that open a product but never close it; the next first discards them
  task automatic send_partial(input int m);
    bit ok;
    for (int k = 0; k < m; k++) begin
      wait_ready(ok);
      if (!ok) return;
      in_valid = 1'b1;
      in_first = (k == 0);
      in_last  = 1'b0;
      a = DW'($urandom);
      b = LANES*DW'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic run_dp(input int sh, input bit relu, input int hold,
                        input bit bubbles, input bit clr_end, input string tag);
    bit ok, stable;
    int lat;
    logic [LANES*DW-1:0] y0;
    model(sh, relu);
    out_ready = 1'b0;
    for (int k = 0; k < nb; k++) begin
      if (bubbles && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      wait_ready(ok);
      if (!ok) return;
      drive_beat(k, k == 0, k == nb - 1, sh, relu);
      @(negedge clk);
    end
    in_valid = 1'b0;
    a = DW'($urandom);
    b = LANES*DW'($urandom);
    lat = 0;
    ovf_clr = clr_end;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 2) ovf_clr = 1'b0;
    end
    ovf_clr = 1'b0;
    check({tag, "_latency"}, lat, 3);
    y0 = y;
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_first = 1'b1;
      in_last  = 1'b1;
      a = DW'($urandom);
      @(negedge clk);
      if (y !== y0 || !out_valid || in_ready) stable = 1'b0;
    end
    in_valid = 1'b0;
    if (hold > 0) check({tag, "_hold_stable"}, stable, 1);
    for (int l = 0; l < LANES; l++) check({tag, "_y"}, ylane(l), exp_y[l]);
    exp_ovf = clr_end ? fin_sat : (exp_ovf | any_sat);
    check({tag, "_overflow"}, overflow, exp_ovf);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_ov_drop"}, out_valid, 0);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  task automatic load_const(input int n, input int av, input int bv [LANES]);
    nb = n;
    for (int k = 0; k < n; k++) begin
      ta[k] = av;
      for (int l = 0; l < LANES; l++) tw[k][l] = bv[l];
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    int nr;
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    a = '0; b = '0; shift = '0; relu_en = 1'b0;
    out_ready = 1'b0; ovf_clr = 1'b0;
    exp_ovf = '0;

    vt[0] = '{3,    '{5, -4, 0, 1},       0,  1'b0, '{15, -12, 0, 3}};
    vt[1] = '{1,    '{-3, 5, 127, -128},  1,  1'b0, '{-1, 3, 64, -64}};
    vt[2] = '{1,    '{-3, 5, 127, -128},  1,  1'b1, '{0, 3, 64, 0}};
    vt[3] = '{-128, '{-128, 127, 1, 2},   0,  1'b0, '{127, -128, -128, -128}};
    vt[4] = '{-128, '{-128, 127, 1, 2},   7,  1'b0, '{127, -127, -1, -2}};
    vt[5] = '{-128, '{-128, 127, 1, 2},   12, 1'b0, '{4, -4, 0, 0}};
    vt[6] = '{-128, '{-128, 127, 1, 2},   31, 1'b0, '{0, 0, 0, 0}};
    vt[7] = '{127,  '{127, -128, 0, -1},  0,  1'b1, '{127, 0, 0, 0}};

    @(negedge clk);
    check("rst_in_ready_low", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_overflow", overflow, 0);
    @(negedge clk);
    check("rst_in_ready_high", in_ready, 1);

    for (int v = 0; v < 8; v++) begin
      load_const(1, vt[v].a, vt[v].b);
      run_dp(vt[v].sh, vt[v].relu, 0, 1'b0, 1'b0, "vec");
      for (int l = 0; l < LANES; l++) check("vec_table_y", ylane(l), vt[v].y[l]);
    end

    load_const(4, 100, '{100, -100, 0, 1});
    run_dp(8, 1'b1, 0, 1'b0, 1'b0, "dp4_relu");
    check("dp4_relu_y0", ylane(0), 127);
    check("dp4_relu_y1", ylane(1), 0);
    check("dp4_relu_y3", ylane(3), 2);
    run_dp(8, 1'b0, 0, 1'b1, 1'b0, "dp4_norelu");
    check("dp4_norelu_y1", ylane(1), -128);

    load_const(8, -128, '{-128, -128, 0, 1});
    run_dp(31, 1'b0, 0, 1'b0, 1'b0, "sat8");
    check("sat8_overflow", overflow, 4'b0011);
    load_const(9, -128, '{-128, 0, 127, 1});
    run_dp(31, 1'b0, 0, 1'b0, 1'b1, "sat9_clr");
    check("sat9_clr_overflow", overflow, 4'b0101);
    check("sat9_neg_y2", ylane(2), -1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    exp_ovf = '0;
    check("ovf_clr_alone", overflow, 0);

    load_const(1, 7, '{9, -9, 1, 0});
    run_dp(0, 1'b0, 10, 1'b0, 1'b0, "bp");
    load_const(2, -5, '{3, 4, -2, 1});
    run_dp(0, 1'b0, 0, 1'b0, 1'b0, "bp_next");
    check("bp_next_y0", ylane(0), -30);

    load_const(2, 50, '{50, 50, 50, 50});
    wait_ready(ok);
    drive_beat(0, 1'b1, 1'b0, 0, 1'b0);
    @(negedge clk);
    drive_beat(1, 1'b0, 1'b1, 0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    ovf_clr = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready_low", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_y", y, 0);
    check("midrst_overflow", overflow, 0);
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1);
    nr = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) nr++;
    end
    check("midrst_no_stale", nr, 0);
    exp_ovf = '0;

    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(0, 2) == 0) send_partial($urandom_range(1, 2));
      nb = $urandom_range(1, 6);
      for (int k = 0; k < nb; k++) begin
        ta[k] = int'($urandom_range(0, 255)) - 128;
        for (int l = 0; l < LANES; l++) tw[k][l] = int'($urandom_range(0, 255)) - 128;
      end
      run_dp($urandom_range(0, 20), 1'($urandom), $urandom_range(0, 3),
             1'b1, 1'b0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
